// File: rtl/mips_encode.sv
// Two-stage MIPS instruction encoder (inverse of mips_decode) with valid/ready
// handshakes on both sides and running counts of emitted and illegal words.

`ifndef MIPS_ENCODE_OPCODES
`define MIPS_ENCODE_OPCODES
`ifndef OP_OTHER0
`define OP_OTHER0 6'h00
`endif
`ifndef OP_J
`define OP_J      6'h02
`endif
`ifndef OP_BEQ
`define OP_BEQ    6'h04
`endif
`ifndef OP_BNE
`define OP_BNE    6'h05
`endif
`ifndef OP_ADDI
`define OP_ADDI   6'h08
`endif
`ifndef OP_ANDI
`define OP_ANDI   6'h0c
`endif
`ifndef OP_ORI
`define OP_ORI    6'h0d
`endif
`ifndef OP_XORI
`define OP_XORI   6'h0e
`endif
`ifndef OP_LUI
`define OP_LUI    6'h0f
`endif
`ifndef OP_LW
`define OP_LW     6'h23
`endif
`ifndef OP_LBU
`define OP_LBU    6'h24
`endif
`ifndef OP_SB
`define OP_SB     6'h28
`endif
`ifndef OP_SW
`define OP_SW     6'h2b
`endif
`ifndef OP0_JR
`define OP0_JR    6'h08
`endif
`ifndef OP0_ADD
`define OP0_ADD   6'h20
`endif
`ifndef OP0_SUB
`define OP0_SUB   6'h22
`endif
`ifndef OP0_AND
`define OP0_AND   6'h24
`endif
`ifndef OP0_OR
`define OP0_OR    6'h25
`endif
`ifndef OP0_XOR
`define OP0_XOR   6'h26
`endif
`ifndef OP0_NOR
`define OP0_NOR   6'h27
`endif
`ifndef OP0_SLT
`define OP0_SLT   6'h2a
`endif
`ifndef OP0_ADDM
`define OP0_ADDM  6'h2c
`endif
`endif

module mips_encode (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_mnem,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] emit_count,
    output logic [7:0]  illegal_count
);

    typedef enum logic [4:0] {
        M_ADD  = 5'd0,  M_SUB  = 5'd1,  M_AND  = 5'd2,  M_OR   = 5'd3,
        M_NOR  = 5'd4,  M_XOR  = 5'd5,  M_ADDI = 5'd6,  M_ANDI = 5'd7,
        M_ORI  = 5'd8,  M_XORI = 5'd9,  M_BEQ  = 5'd10, M_BNE  = 5'd11,
        M_J    = 5'd12, M_JR   = 5'd13, M_LUI  = 5'd14, M_SLT  = 5'd15,
        M_LW   = 5'd16, M_LBU  = 5'd17, M_SW   = 5'd18, M_SB   = 5'd19,
        M_ADDM = 5'd20
    } mnem_t;

    logic        s1_valid;
    logic [4:0]  s1_mnem;
    logic [4:0]  s1_rs;
    logic [4:0]  s1_rt;
    logic [4:0]  s1_rd;
    logic [15:0] s1_imm;
    logic [25:0] s1_target;

    logic        s2_valid;
    logic [31:0] s2_inst;
    logic        s2_err;

    logic        s2_load;
    logic        fire;
    logic [31:0] enc_inst;
    logic        enc_err;

    assign s2_load   = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s2_load;
    assign fire      = s2_valid & out_ready;
    assign out_valid = s2_valid;
    assign out_inst  = s2_inst;
    assign out_err   = s2_err;

    always_comb begin
        enc_inst = '0;
        enc_err  = 1'b0;
        case (s1_mnem)
            M_ADD:  enc_inst = {`OP_OTHER0, s1_rs, s1_rt, s1_rd, 5'b0, `OP0_ADD};
            M_SUB:  enc_inst = {`OP_OTHER0, s1_rs, s1_rt, s1_rd, 5'b0, `OP0_SUB};
            M_AND:  enc_inst = {`OP_OTHER0, s1_rs, s1_rt, s1_rd, 5'b0, `OP0_AND};
            M_OR:   enc_inst = {`OP_OTHER0, s1_rs, s1_rt, s1_rd, 5'b0, `OP0_OR};
            M_NOR:  enc_inst = {`OP_OTHER0, s1_rs, s1_rt, s1_rd, 5'b0, `OP0_NOR};
            M_XOR:  enc_inst = {`OP_OTHER0, s1_rs, s1_rt, s1_rd, 5'b0, `OP0_XOR};
            M_SLT:  enc_inst = {`OP_OTHER0, s1_rs, s1_rt, s1_rd, 5'b0, `OP0_SLT};
            M_ADDM: enc_inst = {`OP_OTHER0, s1_rs, s1_rt, s1_rd, 5'b0, `OP0_ADDM};
            M_JR:   enc_inst = {`OP_OTHER0, s1_rs, 10'b0, 5'b0, `OP0_JR};
            M_ADDI: enc_inst = {`OP_ADDI, s1_rs, s1_rt, s1_imm};
            M_ANDI: enc_inst = {`OP_ANDI, s1_rs, s1_rt, s1_imm};
            M_ORI:  enc_inst = {`OP_ORI,  s1_rs, s1_rt, s1_imm};
            M_XORI: enc_inst = {`OP_XORI, s1_rs, s1_rt, s1_imm};
            M_BEQ:  enc_inst = {`OP_BEQ,  s1_rs, s1_rt, s1_imm};
            M_BNE:  enc_inst = {`OP_BNE,  s1_rs, s1_rt, s1_imm};
            M_LW:   enc_inst = {`OP_LW,   s1_rs, s1_rt, s1_imm};
            M_LBU:  enc_inst = {`OP_LBU,  s1_rs, s1_rt, s1_imm};
            M_SW:   enc_inst = {`OP_SW,   s1_rs, s1_rt, s1_imm};
            M_SB:   enc_inst = {`OP_SB,   s1_rs, s1_rt, s1_imm};
            M_LUI:  enc_inst = {`OP_LUI, 5'b0, s1_rt, s1_imm};
            M_J:    enc_inst = {`OP_J, s1_target};
            default: enc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_mnem       <= '0;
            s1_rs         <= '0;
            s1_rt         <= '0;
            s1_rd         <= '0;
            s1_imm        <= '0;
            s1_target     <= '0;
            s2_valid      <= 1'b0;
            s2_inst       <= '0;
            s2_err        <= 1'b0;
            emit_count    <= '0;
            illegal_count <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_mnem   <= in_mnem;
                    s1_rs     <= in_rs;
                    s1_rt     <= in_rt;
                    s1_rd     <= in_rd;
                    s1_imm    <= in_imm;
                    s1_target <= in_target;
                end
            end
            // S2 data only moves with a real word so a held output never glitches.
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_inst <= enc_inst;
                    s2_err  <= enc_err;
                end
            end
            if (fire) begin
                emit_count <= emit_count + 16'd1;
                if (s2_err && illegal_count != 8'hFF)
                    illegal_count <= illegal_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_encode.sv
// Directed bench for mips_encode: per-mnemonic vector table plus hand-written
// streaming, backpressure, reset and saturation sequences.

module tb_mips_encode;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] emit_count;
    logic [7:0]  illegal_count;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned exp_emit;
    int unsigned exp_ill;

    mips_encode dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mnem(in_mnem),
        .in_rs(in_rs),
        .in_rt(in_rt),
        .in_rd(in_rd),
        .in_imm(in_imm),
        .in_target(in_target),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst(out_inst),
        .out_err(out_err),
        .emit_count(emit_count),
        .illegal_count(illegal_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        in_valid  = 1'b1;
        in_mnem   = m;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, " emit_count"}, {16'b0, emit_count}, exp_emit[31:0] & 32'hFFFF);
        chk({tag, " illegal_count"}, {24'b0, illegal_count}, exp_ill > 255 ? 32'd255 : exp_ill);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_emit = 0;
        exp_ill  = 0;

        vecs[0]  = '{5'd0,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0, 32'h00221820, 1'b0};
        vecs[1]  = '{5'd1,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0, 32'h00221822, 1'b0};
        vecs[2]  = '{5'd2,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0, 32'h00221824, 1'b0};
        vecs[3]  = '{5'd3,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0, 32'h00221825, 1'b0};
        vecs[4]  = '{5'd4,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0, 32'h00221827, 1'b0};
        vecs[5]  = '{5'd5,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0, 32'h00221826, 1'b0};
        vecs[6]  = '{5'd6,  5'd1,  5'd2, 5'd3, 16'h1234, 26'h0, 32'h20221234, 1'b0};
        vecs[7]  = '{5'd7,  5'd1,  5'd2, 5'd3, 16'h1234, 26'h0, 32'h30221234, 1'b0};
        vecs[8]  = '{5'd8,  5'd1,  5'd2, 5'd3, 16'h1234, 26'h0, 32'h34221234, 1'b0};
        vecs[9]  = '{5'd9,  5'd1,  5'd2, 5'd3, 16'h1234, 26'h0, 32'h38221234, 1'b0};
        vecs[10] = '{5'd10, 5'd1,  5'd2, 5'd3, 16'h1234, 26'h0, 32'h10221234, 1'b0};
        vecs[11] = '{5'd11, 5'd1,  5'd2, 5'd3, 16'h1234, 26'h0, 32'h14221234, 1'b0};
        vecs[12] = '{5'd12, 5'd1,  5'd2, 5'd3, 16'h1234, 26'h3FFFFFF, 32'h0BFFFFFF, 1'b0};
        vecs[13] = '{5'd13, 5'd31, 5'd2, 5'd3, 16'h1234, 26'h0, 32'h03E00008, 1'b0};
        vecs[14] = '{5'd14, 5'd1,  5'd2, 5'd3, 16'hBEEF, 26'h0, 32'h3C02BEEF, 1'b0};
        vecs[15] = '{5'd15, 5'd1,  5'd2, 5'd3, 16'h0000, 26'h0, 32'h0022182A, 1'b0};
        vecs[16] = '{5'd16, 5'd1,  5'd2, 5'd3, 16'h1234, 26'h0, 32'h8C221234, 1'b0};
        vecs[17] = '{5'd17, 5'd1,  5'd2, 5'd3, 16'h1234, 26'h0, 32'h90221234, 1'b0};
        vecs[18] = '{5'd18, 5'd1,  5'd2, 5'd3, 16'h1234, 26'h0, 32'hAC221234, 1'b0};
        vecs[19] = '{5'd19, 5'd1,  5'd2, 5'd3, 16'h1234, 26'h0, 32'hA0221234, 1'b0};
        vecs[20] = '{5'd20, 5'd1,  5'd2, 5'd3, 16'h0000, 26'h0, 32'h0022182C, 1'b0};
        vecs[21] = '{5'd31, 5'd1,  5'd2, 5'd3, 16'h1234, 26'h1, 32'h00000000, 1'b1};
        vecs[22] = '{5'd0,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0, 32'h00221820, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        in_valid  = 1'b0;
        #2;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_inst", out_inst, 32'd0);
        chk("reset out_err", {31'b0, out_err}, 32'd0);
        check_counts("reset");
        step();
        step();
        reset = 1'b0;
        #1;
        chk("post-reset in_ready", {31'b0, in_ready}, 32'd1);

        // One word at a time: valid exactly two edges after acceptance.
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].target);
            chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d early valid", i), {31'b0, out_valid}, 32'd0);
            step();
            chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d out_inst", i), out_inst, vecs[i].exp_inst);
            chk($sformatf("v%0d out_err", i), {31'b0, out_err}, {31'b0, vecs[i].exp_err});
            step();
            exp_emit++;
            if (vecs[i].exp_err) exp_ill++;
            chk($sformatf("v%0d drained", i), {31'b0, out_valid}, 32'd0);
            check_counts($sformatf("v%0d", i));
        end

        // Back-to-back stream.
        drive(5'd6, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0);
        chk("stream in_ready0", {31'b0, in_ready}, 32'd1);
        step();
        drive(5'd16, 5'd29, 5'd4, 5'd0, 16'hFFFC, 26'h0);
        chk("stream in_ready1", {31'b0, in_ready}, 32'd1);
        chk("stream valid1", {31'b0, out_valid}, 32'd0);
        step();
        drive(5'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
        chk("stream in_ready2", {31'b0, in_ready}, 32'd1);
        chk("stream valid2", {31'b0, out_valid}, 32'd1);
        chk("stream addi", out_inst, 32'h20220005);
        step();
        in_valid = 1'b0;
        chk("stream valid3", {31'b0, out_valid}, 32'd1);
        chk("stream lw", out_inst, 32'h8FA4FFFC);
        step();
        chk("stream valid4", {31'b0, out_valid}, 32'd1);
        chk("stream j", out_inst, 32'h08100000);
        step();
        chk("stream valid5", {31'b0, out_valid}, 32'd0);
        exp_emit += 3;
        check_counts("stream");

        // Backpressure: two words buffered, third stalled until drain.
        out_ready = 1'b0;
        drive(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        step();
        drive(5'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        chk("bp in_ready1", {31'b0, in_ready}, 32'd1);
        step();
        drive(5'd3, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
        chk("bp in_ready full", {31'b0, in_ready}, 32'd0);
        chk("bp hold A", out_inst, 32'h00221820);
        step();
        chk("bp in_ready still full", {31'b0, in_ready}, 32'd0);
        chk("bp stable valid", {31'b0, out_valid}, 32'd1);
        chk("bp stable A", out_inst, 32'h00221820);
        check_counts("bp held");
        out_ready = 1'b1;
        #1;
        chk("bp in_ready on drain", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp word B", out_inst, 32'h00853022);
        step();
        chk("bp word C", out_inst, 32'h00E84825);
        chk("bp C valid", {31'b0, out_valid}, 32'd1);
        step();
        chk("bp empty", {31'b0, out_valid}, 32'd0);
        exp_emit += 3;
        check_counts("bp");

        // Reset with two words in flight.
        out_ready = 1'b0;
        drive(5'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        step();
        drive(5'd4, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0);
        step();
        in_valid = 1'b0;
        chk("rst pre valid", {31'b0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        exp_emit = 0;
        exp_ill  = 0;
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst out_inst", out_inst, 32'd0);
        check_counts("rst");
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst in_ready", {31'b0, in_ready}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rst no stale %0d", c), {31'b0, out_valid}, 32'd0);
        end
        check_counts("rst after");

        // Saturation of illegal_count.
        drive(5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        for (int c = 0; c < 256; c++) begin
            if (in_ready !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL sat in_ready: got %b, expected 1 at cycle %0d", in_ready, c);
            end
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        step();
        exp_emit += 256;
        exp_ill  += 256;
        check_counts("sat");
        chk("sat illegal 255", {24'b0, illegal_count}, 32'd255);
        chk("sat emit 256", {16'b0, emit_count}, 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_encode.md
# mips_encode

Pipelined MIPS instruction encoder: the inverse of the `mips_decode` control decoder. It accepts a mnemonic code plus register/immediate/target fields over a valid/ready handshake and emits the 32-bit machine word the decoder understands. It covers exactly the decoder's instruction set, including `addm`. It sits between the test-program generator / instruction-memory loader and instruction memory, and keeps running counts of emitted and rejected instructions.

## Interface
- No parameters. Opcode/funct values come from the shared `OP_*` / `OP0_*` defines.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept this cycle
- in_mnem  in  5  mnemonic code:
  - 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor
  - 6 addi, 7 andi, 8 ori, 9 xori
  - 10 beq, 11 bne, 12 j, 13 jr, 14 lui, 15 slt
  - 16 lw, 17 lbu, 18 sw, 19 sb, 20 addm
  - 21–31 illegal
- in_rs, in_rt, in_rd  in  5 each  register numbers
- in_imm  in  16  immediate / branch offset (passed through verbatim)
- in_target  in  26  jump target field
- out_valid  out  1  encoded word present
- out_ready  in  1  consumer accepts word
- out_inst  out  32  encoded instruction
- out_err  out  1  word corresponds to an illegal mnemonic
- emit_count  out  16  words handed off (wraps modulo 2^16)
- illegal_count  out  8  illegal words handed off (saturates at 255)

## Operation
- **R-type** (add, sub, and, or, nor, xor, slt, addm):
  - {`OP_OTHER0`, rs, rt, rd, 5'b0, funct}
  - funct is `OP0_ADD`/`SUB`/`AND`/`OR`/`NOR`/`XOR`/`SLT`/`ADDM`.
- **jr:** {`OP_OTHER0`, rs, 10'b0, 5'b0, `OP0_JR`}; in_rt and in_rd are ignored.
- **I-type** (addi, andi, ori, xori, beq, bne, lw, lbu, sw, sb):
  - {opcode, rs, rt, imm}
  - No sign/zero manipulation; in_imm is copied as given.
- **lui:** {`OP_LUI`, 5'b0, rt, imm}; in_rs is ignored.
- **j:** {`OP_J`, target}.
- **Illegal mnemonic:**
  - out_inst = 32'h0, out_err = 1.
  - The request is still consumed and still travels the pipeline.
- **Pipeline:**
  - Stage 1 (S1) registers the mnemonic and fields.
  - Stage 2 (S2) registers the encoded word and err flag.
  - Each stage has its own valid bit.
- **Stage advance rules:**
  - S2 loads when ~s2_valid | out_ready.
  - S1 loads when ~s1_valid | S1 advancing into S2.
  - in_ready = ~s1_valid | (~s2_valid | out_ready). It is combinational and must not depend on in_valid.
- **Counters:**
  - emit_count increments on every out_valid & out_ready cycle.
  - illegal_count increments on the same condition when out_err = 1, stopping at 8'hFF.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - s1_valid = s2_valid = 0, so out_valid = 0.
  - out_inst = 0, out_err = 0.
  - emit_count = 0, illegal_count = 0.
  - in_ready = 1 once out of reset.
- **Latency:** a request accepted at edge N is presented on out_valid/out_inst after edge N+1. That is 2 clock edges from acceptance (acceptance edge + S2 load edge).
- **Throughput:** 1 word/cycle while out_ready = 1.
- **Backpressure:**
  - out_ready low with both stages full → in_ready = 0.
  - At most 2 words buffered.
  - No word is ever dropped or duplicated.
- **Output stability:** out_inst and out_err are stable while out_valid & ~out_ready.
- **Simultaneous events:** accept and emit in the same cycle with a full pipe is legal; both stages advance together.
- **Reset mid-operation:** in-flight words are discarded and counters return to 0. No partial word appears after reset is released.
- **Count wrap:** emit_count 16'hFFFF + 1 = 16'h0000.

## Test plan
- add (rs=1, rt=2, rd=3), out_ready=1 → out_inst 32'h00221820, out_err 0, valid exactly 2 edges after acceptance; emit_count = 1.
- Back-to-back stream, one per cycle, out_ready=1:
  - addi (rs=1, rt=2, imm=5) → 32'h20220005
  - lw (rs=29, rt=4, imm=16'hFFFC) → 32'h8FA4FFFC
  - j (target=26'h0100000) → 32'h08100000
  - Require: one word per cycle, in order, in_ready stays 1.
- Illegal mnemonic 31 → out_inst 0, out_err 1, illegal_count 1, emit_count 1; a following add still encodes correctly.
- Backpressure: out_ready=0 and offer 3 requests → only 2 accepted, in_ready = 0 on the 3rd. First word is held stable. Raising out_ready drains the 2 words in order, then the 3rd is accepted.
- Assert reset with 2 words in flight → out_valid drops immediately, counters 0, in_ready 1 after release, no stale word emitted.
- 256 consecutive illegal requests → illegal_count saturates at 255, emit_count = 256.
